// File: rtl/icache_axi_bridge_pkg.sv
// Shared definitions for the instruction-cache line-refill AXI bridge.
package icache_axi_bridge_pkg;

    localparam int unsigned LINE_WORDS = 4;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAr    = 2'd1,
        StData  = 2'd2,
        StDrain = 2'd3
    } bridge_state_e;

endpackage

// File: rtl/icache_axi_bridge_if.sv
// Cache-side request/response and AXI read-channel signals of the refill bridge.
// master: the bridge itself; slave: the cache plus AXI memory environment.
interface icache_axi_bridge_if;

    // cache side
    logic        i_arvalid;
    logic        i_arready;
    logic [31:0] i_araddr;
    logic        i_rvalid;
    logic        i_rready;
    logic [31:0] i_rdata;
    logic        i_rlast;

    // AXI AR channel
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    // AXI R channel
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    modport master (
        input  i_arvalid, i_araddr, i_rready,
        output i_arready, i_rvalid, i_rdata, i_rlast,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready
    );

    modport slave (
        output i_arvalid, i_araddr, i_rready,
        input  i_arready, i_rvalid, i_rdata, i_rlast,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready
    );

endinterface

// File: rtl/icache_rbuf_fifo2.sv
// Two-entry registered FIFO buffering AXI read beats toward the cache.
module icache_rbuf_fifo2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    // A push into a full FIFO is allowed when the head leaves in the same cycle:
    // it lands in the slot being vacated.
    assign w_push  = i_push && (!o_full || i_pop);
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rptr];

    // Storage, pointers and occupancy; storage cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

endmodule

// File: rtl/icache_axi_bridge.sv
// Instruction-cache line-refill bridge: one 4-beat INCR AXI read burst per cache miss.
// Optional feature macro: ICACHE_AXI_ERR_CHECK_EN enables the sticky bus_err flag
// (rresp, rid and rlast checking); without it bus_err is tied low.
module icache_axi_bridge #(
    parameter logic [3:0]  AXI_ID     = 4'h0,
    parameter int unsigned LINE_WORDS = icache_axi_bridge_pkg::LINE_WORDS
) (
    input  logic                clk,
    input  logic                rstn,
    icache_axi_bridge_if.master bus,
    output logic                bus_err
);
    import icache_axi_bridge_pkg::*;

    localparam logic [1:0] LastBeat = 2'(LINE_WORDS - 1);

    bridge_state_e r_state;
    bridge_state_e w_state_nxt;
    logic [31:0]   r_addr;
    logic [1:0]    r_in_cnt;
    logic [1:0]    r_out_cnt;
    logic          w_rready;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [31:0]   w_head;

    assign w_rready = (r_state == StData) && !w_full;
    assign w_push   = bus.rvalid && w_rready;
    assign w_pop    = !w_empty && bus.i_rready;

    assign bus.rready   = w_rready;
    assign bus.araddr   = r_addr;
    assign bus.arid     = AXI_ID;
    assign bus.arlen    = 8'(LINE_WORDS - 1);
    assign bus.arsize   = SIZE_4B;
    assign bus.arburst  = BURST_INCR;
    assign bus.i_rvalid = !w_empty;
    assign bus.i_rdata  = w_head;
    // Last flag comes from our own delivery count, never from AXI rlast.
    assign bus.i_rlast  = !w_empty && (r_out_cnt == LastBeat);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and request handshake outputs.
    always_comb begin
        w_state_nxt   = r_state;
        bus.i_arready = 1'b0;
        bus.arvalid   = 1'b0;
        unique case (r_state)
            StIdle: begin
                bus.i_arready = 1'b1;
                if (bus.i_arvalid) w_state_nxt = StAr;
            end
            StAr: begin
                bus.arvalid = 1'b1;
                if (bus.arready) w_state_nxt = StData;
            end
            StData: begin
                if (w_push && (r_in_cnt == LastBeat)) w_state_nxt = StDrain;
            end
            StDrain: begin
                if (w_pop && (r_out_cnt == LastBeat)) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Line-aligned address capture on request acceptance.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr <= '0;
        end else if ((r_state == StIdle) && bus.i_arvalid) begin
            r_addr <= {bus.i_araddr[31:4], 4'h0};
        end
    end

    // Beat counters: accepted from AXI and delivered to the cache; both wrap per line.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_in_cnt  <= 2'd0;
            r_out_cnt <= 2'd0;
        end else begin
            if (w_push) r_in_cnt <= r_in_cnt + 2'd1;
            if (w_pop)  r_out_cnt <= r_out_cnt + 2'd1;
        end
    end

    icache_rbuf_fifo2 #(
        .WIDTH (32)
    ) u_rbuf (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_wdata (bus.rdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef ICACHE_AXI_ERR_CHECK_EN
    logic r_bus_err;
    logic w_beat_err;

    assign w_beat_err = (bus.rresp != RESP_OKAY) || (bus.rid != AXI_ID) ||
                        (bus.rlast != (r_in_cnt == LastBeat));

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bus_err <= 1'b0;
        end else if (w_push && w_beat_err) begin
            r_bus_err <= 1'b1;
        end
    end

    assign bus_err = r_bus_err;
`else
    logic unused_err_sigs;
    assign unused_err_sigs = ^{bus.rresp, bus.rid, bus.rlast};
    assign bus_err = 1'b0;
`endif

endmodule

// File: doc/icache_axi_bridge.md
ICACHE_AXI_BRIDGE -- requirements
Module: icache_axi_bridge

Interface
REQ-001 SHALL have parameters: AXI_ID, default 4'h0, ARID driven on every request; LINE_WORDS, default 4, 32-bit words per cache line (fixed at 4 in this revision).
REQ-002 SHALL have ports: clk in 1 clock; rstn in 1 async active-low reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have cache-side ports: i_arvalid in 1; i_arready out 1; i_araddr in 32 line address; i_rvalid out 1; i_rready in 1; i_rdata out 32; i_rlast out 1.
REQ-004 SHALL have AXI-side ports: arvalid out 1; arready in 1; araddr out 32; arid out 4; arlen out 8; arsize out 3; arburst out 2; rvalid in 1; rready out 1; rdata in 32; rresp in 2; rlast in 1; rid in 4.
REQ-005 SHALL have status port: bus_err out 1, sticky error flag (see REQ-021).

Function
REQ-006 SHALL implement FSM states IDLE, AR, DATA, DRAIN; one line refill outstanding at a time.
REQ-007 IDLE: i_arready=1; on i_arvalid capture {i_araddr[31:4],4'h0} into addr register, go AR next cycle.
REQ-008 AR: arvalid=1, araddr=captured address, arid=AXI_ID, arlen=8'd3, arsize=3'b010, arburst=2'b01 (INCR); arvalid held with stable fields until arready; on arvalid&&arready go DATA.
REQ-009 i_arready SHALL be 0 in every state except IDLE; arvalid SHALL be 0 in every state except AR.
REQ-010 DATA: R beats enter a 2-entry FIFO (data+last); rready = FIFO not full; beat accepted when rvalid&&rready.
REQ-011 Cache side: i_rvalid = FIFO not empty; i_rdata/i_rlast from FIFO head; pop on i_rvalid&&i_rready.
REQ-012 i_rlast SHALL be generated by a 2-bit bridge beat counter (asserted on 4th beat delivered), independent of AXI rlast.
REQ-013 Simultaneous push and pop on a full or empty FIFO SHALL both take effect; occupancy unchanged when both occur; no beat lost or duplicated.
REQ-014 Latency: beat accepted on AXI in cycle N SHALL be visible on i_rvalid in cycle N+1 (registered FIFO).
REQ-015 After 4th AXI beat accepted go DRAIN; rready=0 in DRAIN; return to IDLE in cycle after last beat popped by cache.
REQ-016 Beats with rid != AXI_ID SHALL still be accepted (single master) and set bus_err when error capture is enabled.
REQ-017 AXI rlast asserted on a beat other than the 4th, or absent on the 4th, SHALL set bus_err (when enabled); refill still completes after 4 beats.
REQ-018 New i_arvalid while not IDLE SHALL be ignored (i_arready=0) and not queued.

Reset
REQ-019 On rstn low (any cycle, incl. mid-burst): state=IDLE, FIFO empty, beat counter=0, addr register=0, bus_err=0; outputs i_arready=1, arvalid=0, rready=0, i_rvalid=0, i_rlast=0, araddr=0, i_rdata=0.
REQ-020 Beats in flight at reset SHALL be discarded; no cache-side beat emitted after reset until a new request.

Configuration
REQ-021 Macro ICACHE_AXI_ERR_CHECK_EN: defined -> bus_err set on rresp!=2'b00, rid mismatch, or rlast mismatch, cleared only by reset; undefined -> bus_err tied 0, no rresp/rid/rlast checking logic.

Structure
REQ-022 Shared package SHALL hold: bridge state encoding (IDLE=0,AR=1,DATA=2,DRAIN=3), AXI constants (BURST_INCR=2'b01, SIZE_4B=3'b010, RESP_OKAY=2'b00), LINE_WORDS.
REQ-023 The 2-entry FIFO SHALL be a sub-module named icache_rbuf_fifo2 (width param, push/pop/full/empty).

Verification
REQ-024 i_araddr=32'h1C00_0038, arready high immediately, 4 beats back-to-back, i_rready=1 -> araddr=32'h1C00_0030, arlen=3, i_rlast on 4th beat only, IDLE 1 cycle after last pop.
REQ-025 arready delayed 5 cycles -> arvalid and araddr stable all 5 cycles, i_arready=0 throughout.
REQ-026 i_rready=0 for 4 cycles during burst -> rready drops after 2 beats buffered, all 4 data words delivered in order, none dropped.
REQ-027 rresp=2'b10 on beat 2 (macro defined) -> bus_err=1 next cycle and stays 1; macro undefined -> bus_err=0, refill completes normally.
REQ-028 rstn low after beat 2 accepted -> all outputs at REQ-019 values; following request 32'h0000_0040 completes with fresh 4-beat i_rlast count.
